// File: rtl/keypad_if.sv
// Keypad scanner bus: row drive and column sense toward the keypad, plus
// the key-acceptance pulses and the latched digit toward the consumer.
//
// Signalling contract: there is no valid/ready handshake on this bus. Each
// keydown_* output is a one-cycle strobe that the consumer must sample in
// the cycle it is high; it is never held or retried, and at most one strobe
// is high in any cycle. num is a level that changes only in the same cycle
// as a keydown_num strobe. dbg_state mirrors the debounce FSM state.
interface keypad_if;
  logic [3:0] col;
  logic [3:0] row;
  logic       keydown_num;
  logic       keydown_start;
  logic       keydown_clear;
  logic       keydown_confirm;
  logic [3:0] num;
  logic [1:0] dbg_state;

  // Scanner side.
  modport master (
    input  col,
    output row,
    output keydown_num,
    output keydown_start,
    output keydown_clear,
    output keydown_confirm,
    output num,
    output dbg_state
  );

  // Keypad and consumer side.
  modport slave (
    output col,
    input  row,
    input  keydown_num,
    input  keydown_start,
    input  keydown_clear,
    input  keydown_confirm,
    input  num,
    input  dbg_state
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with full-scan debouncing.
// Rows are driven low one at a time, each for SCAN_DIV cycles; the
// synchronized columns are sampled in the last cycle of each row slot. After
// every full scan the result (none / one key / several keys) feeds a
// debounce FSM that issues one acceptance pulse per press.
// Optional feature: define KEYPAD_REPEAT_EN to make a held numeric key
// re-pulse keydown_num every REPEAT_SCANS full scans.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_N   = 4,
  parameter int unsigned REPEAT_SCANS = 250
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);

`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PRESS_DEB   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_DEB = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    K_NONE    = 3'd0,
    K_NUM     = 3'd1,
    K_START   = 3'd2,
    K_CLEAR   = 3'd3,
    K_CONFIRM = 3'd4
  } key_kind_e;

  // Key code is {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic key_kind_e key_kind(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
      4'd8, 4'd9, 4'd10, 4'd13: key_kind = K_NUM;
      4'd3:                     key_kind = K_START;
      4'd7:                     key_kind = K_CLEAR;
      4'd11:                    key_kind = K_CONFIRM;
      default:                  key_kind = K_NONE;
    endcase
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] code);
    case (code)
      4'd0:    key_digit = 4'd1;
      4'd1:    key_digit = 4'd2;
      4'd2:    key_digit = 4'd3;
      4'd4:    key_digit = 4'd4;
      4'd5:    key_digit = 4'd5;
      4'd6:    key_digit = 4'd6;
      4'd8:    key_digit = 4'd7;
      4'd9:    key_digit = 4'd8;
      4'd10:   key_digit = 4'd9;
      default: key_digit = 4'd0;
    endcase
  endfunction

  // Column synchronizer.
  logic [3:0] r_col_s1;
  logic [3:0] r_col_s2;

  // Scan timing.
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [1:0]        r_row_idx;
  logic              w_slot_last;
  logic              w_scan_done;

  // Per-scan key accumulation (hits saturate at 2 = MULTI).
  logic [1:0] r_acc_hits;
  logic [3:0] r_acc_code;
  logic [1:0] w_row_hits;
  logic [3:0] w_row_code;
  logic [2:0] w_sum;
  logic [1:0] w_tot_hits;
  logic [3:0] w_tot_code;
  logic       w_res_valid;

  // Debounce FSM.
  state_e      r_state;
  state_e      w_next_state;
  logic [3:0]  r_cand;
  logic [3:0]  w_next_cand;
  logic [3:0]  r_deb_cnt;
  logic [3:0]  w_next_deb;
  logic [3:0]  w_deb_inc;
  logic [15:0] r_rep_cnt;
  logic [15:0] w_next_rep;
  logic [15:0] w_rep_inc;
  logic        w_same;
  logic        w_fire;
  logic [3:0]  w_fire_code;
  key_kind_e   w_fire_kind;

  // Registered outputs.
  logic       r_kd_num;
  logic       r_kd_start;
  logic       r_kd_clear;
  logic       r_kd_confirm;
  logic [3:0] r_num;

  // Two-flop synchronizer; idles high because the columns are pulled up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= kp.col;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_slot_last = (r_slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign w_scan_done = w_slot_last && (r_row_idx == 2'd3);

  // Free-running slot counter and row pointer; never stalled by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_row_idx  <= 2'd0;
    end else if (w_slot_last) begin
      r_slot_cnt <= '0;
      r_row_idx  <= r_row_idx + 2'd1;
    end else begin
      r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
    end
  end

  assign kp.row = ~(4'b0001 << r_row_idx);

  // Count low columns of the current row and remember the last one found.
  always_comb begin
    w_row_hits = 2'd0;
    w_row_code = {r_row_idx, 2'b00};
    for (int c = 0; c < 4; c++) begin
      if (!r_col_s2[c]) begin
        if (w_row_hits != 2'd2) w_row_hits = w_row_hits + 2'd1;
        w_row_code = {r_row_idx, 2'(c)};
      end
    end
  end

  assign w_sum       = {1'b0, r_acc_hits} + {1'b0, w_row_hits};
  assign w_tot_hits  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_tot_code  = (w_row_hits != 2'd0) ? w_row_code : r_acc_code;
  assign w_res_valid = w_scan_done && (w_tot_hits == 2'd1);

  // Accumulate row samples across one scan; clear when the scan completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_hits <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_scan_done) begin
      r_acc_hits <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_slot_last) begin
      r_acc_hits <= w_tot_hits;
      r_acc_code <= w_tot_code;
    end
  end

  assign w_same    = w_res_valid && (w_tot_code == r_cand);
  assign w_deb_inc = r_deb_cnt + 4'd1;
  assign w_rep_inc = r_rep_cnt + 16'd1;

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cand    <= 4'd0;
      r_deb_cnt <= 4'd0;
      r_rep_cnt <= 16'd0;
    end else begin
      r_state   <= w_next_state;
      r_cand    <= w_next_cand;
      r_deb_cnt <= w_next_deb;
      r_rep_cnt <= w_next_rep;
    end
  end

  // Next state: evaluated only on the cycle that completes a full scan.
  // MULTI (hits = 2) never sets w_res_valid, so it behaves like NONE.
  always_comb begin
    w_next_state = r_state;
    w_next_cand  = r_cand;
    w_next_deb   = r_deb_cnt;
    w_next_rep   = r_rep_cnt;
    w_fire       = 1'b0;
    w_fire_code  = r_cand;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_res_valid) begin
            w_next_cand = w_tot_code;
            w_fire_code = w_tot_code;
            if (DEBOUNCE_N <= 1) begin
              w_next_state = S_HELD;
              w_next_deb   = 4'd0;
              w_next_rep   = 16'd0;
              w_fire       = 1'b1;
            end else begin
              w_next_state = S_PRESS_DEB;
              w_next_deb   = 4'd1;
            end
          end
        end
        S_PRESS_DEB: begin
          if (w_same) begin
            if (w_deb_inc >= 4'(DEBOUNCE_N)) begin
              w_next_state = S_HELD;
              w_next_deb   = 4'd0;
              w_next_rep   = 16'd0;
              w_fire       = 1'b1;
            end else begin
              w_next_deb = w_deb_inc;
            end
          end else begin
            // A different key or no key restarts from IDLE on the next scan.
            w_next_state = S_IDLE;
            w_next_deb   = 4'd0;
          end
        end
        S_HELD: begin
          if (w_same) begin
            if (REPEAT_ON && (key_kind(r_cand) == K_NUM)) begin
              if (w_rep_inc >= 16'(REPEAT_SCANS)) begin
                w_next_rep = 16'd0;
                w_fire     = 1'b1;
              end else begin
                w_next_rep = w_rep_inc;
              end
            end
          end else if (DEBOUNCE_N <= 1) begin
            w_next_state = S_IDLE;
            w_next_deb   = 4'd0;
          end else begin
            w_next_state = S_RELEASE_DEB;
            w_next_deb   = 4'd1;
          end
        end
        S_RELEASE_DEB: begin
          if (w_same) begin
            w_next_state = S_HELD;
            w_next_deb   = 4'd0;
            w_next_rep   = 16'd0;
          end else if (w_deb_inc >= 4'(DEBOUNCE_N)) begin
            w_next_state = S_IDLE;
            w_next_deb   = 4'd0;
          end else begin
            w_next_deb = w_deb_inc;
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_deb   = 4'd0;
        end
      endcase
    end
  end

  assign w_fire_kind = key_kind(w_fire_code);

  // Acceptance strobes and latched digit, one cycle after the deciding sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kd_num     <= 1'b0;
      r_kd_start   <= 1'b0;
      r_kd_clear   <= 1'b0;
      r_kd_confirm <= 1'b0;
      r_num        <= 4'd0;
    end else begin
      r_kd_num     <= w_fire && (w_fire_kind == K_NUM);
      r_kd_start   <= w_fire && (w_fire_kind == K_START);
      r_kd_clear   <= w_fire && (w_fire_kind == K_CLEAR);
      r_kd_confirm <= w_fire && (w_fire_kind == K_CONFIRM);
      if (w_fire && (w_fire_kind == K_NUM)) r_num <= key_digit(w_fire_code);
    end
  end

  assign kp.keydown_num     = r_kd_num;
  assign kp.keydown_start   = r_kd_start;
  assign kp.keydown_clear   = r_kd_clear;
  assign kp.keydown_confirm = r_kd_confirm;
  assign kp.num             = r_num;
  assign kp.dbg_state       = r_state;

endmodule
